// File: rtl/aes_subbytes_serial.sv
// rtl/aes_subbytes_serial.sv - Serial AES SubBytes stage, SBOX_COUNT bytes per cycle
// Optional macro SBOX_OUT_REG_EN inserts a register stage after the S-boxes.

module aes_sbox_canright_verified (
  input  logic [7:0] a,
  input  logic       enc_dec,
  output logic [7:0] q
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] acc;
    logic [7:0] b;
    acc = 8'h00;
    b   = x;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) acc = acc ^ b;
      b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as SubBytes requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] b);
    logic [7:0] s;
    for (int i = 0; i < 8; i++)
      s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8];
    return s ^ 8'h63;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] b);
    logic [7:0] s;
    for (int i = 0; i < 8; i++)
      s[i] = b[(i + 7) % 8] ^ b[(i + 5) % 8] ^ b[(i + 2) % 8];
    return s ^ 8'h05;
  endfunction

  // One shared field inverter serves both directions.
  logic [7:0] pre;
  logic [7:0] inv_v;

  assign pre   = enc_dec ? a : affine_inv(a);
  assign inv_v = gf_inv(pre);
  assign q     = enc_dec ? affine_fwd(inv_v) : inv_v;

endmodule

module aes_subbytes_serial #(
  parameter int SBOX_COUNT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_enc_dec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int GROUPS = 16 / SBOX_COUNT;
`ifdef SBOX_OUT_REG_EN
  localparam int LAST_CNT = GROUPS;
`else
  localparam int LAST_CNT = GROUPS - 1;
`endif
  localparam int CW = (LAST_CNT > 0) ? $clog2(LAST_CNT + 1) : 1;

  generate
    if (!(SBOX_COUNT == 1 || SBOX_COUNT == 2 || SBOX_COUNT == 4 ||
          SBOX_COUNT == 8 || SBOX_COUNT == 16)) begin : g_bad_sbox_count
      $error("SBOX_COUNT must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   grp_q;
  logic            enc_q;
  logic [7:0]      lat_q [16];
  logic [7:0]      res_q [16];
  logic            run_last;

  logic [3:0]      lane    [SBOX_COUNT];
  logic [7:0]      sb_out  [SBOX_COUNT];
  logic            res_we;
  logic [3:0]      res_lane [SBOX_COUNT];
  logic [7:0]      res_data [SBOX_COUNT];

  for (genvar i = 0; i < SBOX_COUNT; i++) begin : g_sbox
    assign lane[i] = 4'((32'(grp_q) * SBOX_COUNT) + i);
    aes_sbox_canright_verified u_sbox (
      .a       (lat_q[lane[i]]),
      .enc_dec (enc_q),
      .q       (sb_out[i])
    );
  end

`ifdef SBOX_OUT_REG_EN
  logic [7:0]    pipe_q [SBOX_COUNT];
  logic [CW-1:0] pipe_grp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_grp_q <= '0;
      for (int i = 0; i < SBOX_COUNT; i++) pipe_q[i] <= '0;
    end else if (state_q == RUN) begin
      pipe_grp_q <= grp_q;
      for (int i = 0; i < SBOX_COUNT; i++) pipe_q[i] <= sb_out[i];
    end
  end

  // The first RUN cycle only fills the pipe; writes trail issue by one cycle.
  assign res_we = (state_q == RUN) && (grp_q != '0);
  for (genvar i = 0; i < SBOX_COUNT; i++) begin : g_res
    assign res_lane[i] = 4'((32'(pipe_grp_q) * SBOX_COUNT) + i);
    assign res_data[i] = pipe_q[i];
  end
`else
  assign res_we = (state_q == RUN);
  for (genvar i = 0; i < SBOX_COUNT; i++) begin : g_res
    assign res_lane[i] = lane[i];
    assign res_data[i] = sb_out[i];
  end
`endif

  assign run_last = (grp_q == CW'(LAST_CNT));

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (run_last) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grp_q   <= '0;
      enc_q   <= 1'b1;
      for (int i = 0; i < 16; i++) begin
        lat_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        grp_q <= '0;
        enc_q <= in_enc_dec;
        for (int i = 0; i < 16; i++) lat_q[i] <= in_state[127 - 8*i -: 8];
      end else if (state_q == RUN) begin
        grp_q <= grp_q + CW'(1);
      end
      if (res_we) begin
        for (int i = 0; i < SBOX_COUNT; i++) res_q[res_lane[i]] <= res_data[i];
      end
    end
  end

  always_comb begin
    out_state = '0;
    for (int i = 0; i < 16; i++) out_state[127 - 8*i -: 8] = res_q[i];
  end

endmodule
